// File: rtl/obi_data_mem_responder_if.sv
// obi_data_mem_responder_if: OBI data-bus signals between an initiator and the memory responder
interface obi_data_mem_responder_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   modport master (output req_i, addr_i, we_i, be_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
   modport slave  (input req_i, addr_i, we_i, be_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/obi_data_mem_responder.sv
// obi_data_mem_responder: OBI data-bus SRAM responder, fixed-latency in-order responses; OBI_DATA_MEM_RESPONDER_RANDOM_STALL_EN adds LFSR grant stalls
module obi_data_mem_responder #(
   parameter int DEPTH           = 4096,
   parameter int RESP_LAT        = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   obi_data_mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   logic [31:0]         mem [DEPTH];
   logic [AW-1:0]       idx;
   logic [CW-1:0]       outstanding;
   logic [RESP_LAT-1:0] pipe_v;
   logic [RESP_LAT-1:0] pipe_r;
   logic [31:0]         pipe_d [RESP_LAT];
   logic                stall;
   logic                accept;
   logic                unused_addr;
   assign idx         = bus.addr_i[2 +: AW];
   assign unused_addr = ^bus.addr_i;
`ifdef OBI_DATA_MEM_RESPONDER_RANDOM_STALL_EN
   logic [15:0] lfsr;
   // Fibonacci LFSR (taps 16,14,13,11) free-running to randomly withhold the grant
   always_ff @(posedge clk_i) begin
      if (!rst_ni) lfsr <= 16'hACE1;
      else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall = lfsr[0] & lfsr[1];
`else
   assign stall = 1'b0;
`endif
   assign bus.gnt_o    = rst_ni & bus.req_i & (outstanding < CW'(MAX_OUTSTANDING)) & ~stall;
   assign accept       = bus.req_i & bus.gnt_o;
   assign bus.rvalid_o = pipe_v[RESP_LAT-1];
   assign bus.rdata_o  = (pipe_v[RESP_LAT-1] & pipe_r[RESP_LAT-1]) ? pipe_d[RESP_LAT-1] : '0;
   // Byte-enabled write commit; memory is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (accept & bus.we_i)
         for (int b = 0; b < 4; b++)
            if (bus.be_i[b]) mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
   end
   // Response control pipeline and outstanding counter, both dropped by reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pipe_v      <= '0;
         pipe_r      <= '0;
         outstanding <= '0;
      end else begin
         pipe_v[0] <= accept;
         pipe_r[0] <= accept & ~bus.we_i;
         for (int i = 1; i < RESP_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_r[i] <= pipe_r[i-1];
         end
         outstanding <= outstanding + CW'(accept) - CW'(bus.rvalid_o);
      end
   end
   // Read data pipeline; word sampled before any same-edge write, masked at the output when not a read
   always_ff @(posedge clk_i) begin
      pipe_d[0] <= mem[idx];
      for (int i = 1; i < RESP_LAT; i++) pipe_d[i] <= pipe_d[i-1];
   end
endmodule

// File: tb/tb_obi_data_mem_responder.sv
// tb_obi_data_mem_responder: random and directed traffic checked against a queue/array reference model
module tb_obi_data_mem_responder;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;
   localparam int MAXO  = 2;
   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          stalls = 0;
   rsp_t        q[$];
   logic [31:0] mem_m [DEPTH];
   obi_data_mem_responder_if bus();
   obi_data_mem_responder #(.DEPTH(DEPTH), .RESP_LAT(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h cycle=%0d", tag, act, exp, cyc);
      end
   endtask
   // reference model: outstanding = queue size, responses due LAT cycles after accept
   always @(negedge clk_i) begin
      logic        exp_rv;
      logic        exp_gnt;
      int          wi;
      logic [31:0] word;
      if (!rst_ni) begin
         chk("gnt_in_reset", {31'b0, bus.gnt_o}, 32'd0);
         q.delete();
      end else begin
         exp_rv = q.size() > 0 && q[0].due == cyc;
         chk("rvalid", {31'b0, bus.rvalid_o}, {31'b0, exp_rv});
         chk("rdata", bus.rdata_o, exp_rv ? q[0].data : 32'd0);
         exp_gnt = bus.req_i && q.size() < MAXO;
`ifdef OBI_DATA_MEM_RESPONDER_RANDOM_STALL_EN
         chk("gnt_illegal", {31'b0, bus.gnt_o & ~exp_gnt}, 32'd0);
         if (exp_gnt && !bus.gnt_o) stalls++;
`else
         chk("gnt", {31'b0, bus.gnt_o}, {31'b0, exp_gnt});
`endif
         if (exp_rv) void'(q.pop_front());
         if (bus.req_i && bus.gnt_o) begin
            wi = int'(bus.addr_i >> 2) % DEPTH;
            word = mem_m[wi];
            q.push_back('{due: cyc + LAT, data: bus.we_i ? 32'd0 : word});
            if (bus.we_i)
               for (int b = 0; b < 4; b++)
                  if (bus.be_i[b]) word[8*b +: 8] = bus.wdata_i[8*b +: 8];
            mem_m[wi] = word;
         end
      end
   end
   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      int n = 0;
      bus.req_i = 1'b1;
      bus.we_i = w;
      bus.addr_i = a;
      bus.be_i = b;
      bus.wdata_i = d;
      do begin
         @(negedge clk_i);
         n++;
      end while (!bus.gnt_o && n < 50);
      if (!bus.gnt_o) chk("grant_timeout", 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
      bus.req_i = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.req_i = 1'b0;
      bus.we_i = 1'b0;
      bus.addr_i = '0;
      bus.be_i = '0;
      bus.wdata_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      bus.req_i = 1'b1;
      @(negedge clk_i);
      chk("gnt_reset_req", {31'b0, bus.gnt_o}, 32'd0);
      @(posedge clk_i);
      #1;
      bus.req_i = 1'b0;
      rst_ni = 1'b1;
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      issue(1'b1, 32'h14, 4'hF, 32'h11223344);
      issue(1'b1, 32'h14, 4'h5, 32'hAABBCCDD);
      issue(1'b0, 32'h14, 4'h0, 32'h0);
      issue(1'b1, 32'h00, 4'hF, 32'hCAFE0001);
      issue(1'b0, 32'h40, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk_i);
      #1;
      for (int i = 0; i < 6; i++) issue(1'b0, 32'h10, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk_i);
      #1;
      for (int i = 0; i < 3; i++) issue(1'b0, 32'h14, 4'h0, 32'h0);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      issue(1'b0, 32'h00, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk_i);
      #1;
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom);
      for (int i = 0; i < 200; i++) begin
         issue(1'($urandom_range(1)), $urandom, 4'($urandom), $urandom);
         if ($urandom_range(3) == 0) begin
            @(posedge clk_i);
            #1;
         end
      end
      repeat (LAT + 2) @(negedge clk_i);
      chk("drained", 32'(q.size()), 32'd0);
`ifdef OBI_DATA_MEM_RESPONDER_RANDOM_STALL_EN
      chk("stall_seen", {31'b0, stalls > 0}, 32'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
